sp_ctrl: RTL and testbench

Parametrised stack-pointer controller for the single-cycle processor datapath. Tracks a full-range, word-addressed, downward-growing stack that starts at a configurable base. It turns push, pop, replace and direct-load requests into the data-memory address and write strobe. It keeps the SP register, occupancy, full/empty status and sticky overflow/underflow error flags. It replaces the fixed single-register stack pointer and sits between the control unit and data memory.

---
 rtl/sp_ctrl.sv | 139 +++++++++++++
 tb/tb_sp_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sp_ctrl.sv
// Stack-pointer controller: empty-descending stack, push/pop/replace/load decode to a data-memory address and write strobe.
// Latency: mem_addr/mem_we are combinational; sp/count/flags update on the next edge. No backpressure, one command per cycle.
// SP_BOUNDS_CHECK_EN enables full/empty guarding, load range checks and the sticky overflow/underflow/bad_load flags.
module sp_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int STACK_BASE  = 900,
  parameter int STACK_DEPTH = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              bad_load
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(STACK_BASE - STACK_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH = CNT_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_nxt;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] sp_dec;
  logic [CNT_W-1:0]  count_q;
  logic              we_c;
  logic              push_blk;
  logic              pop_blk;
  logic              load_ok;

  assign sp_inc = sp_q + ADDR_W'(1);
  assign sp_dec = sp_q - ADDR_W'(1);

  assign sp    = sp_q;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);

  // Command priority: load, replace (push&pop), push, pop, idle.
  always_comb begin
    sp_nxt   = sp_q;
    mem_addr = sp_q;
    we_c     = 1'b0;
    if (load) begin
      if (load_ok) begin
        sp_nxt = load_value;
      end
    end else if (push && pop) begin
      if (!pop_blk) begin
        mem_addr = sp_inc;
        we_c     = 1'b1;
      end
    end else if (push) begin
      if (!push_blk) begin
        we_c   = 1'b1;
        sp_nxt = sp_dec;
      end
    end else if (pop) begin
      if (!pop_blk) begin
        mem_addr = sp_inc;
        sp_nxt   = sp_inc;
      end
    end
  end

  // The strobe must drop the instant reset asserts, not on the next edge.
  assign mem_we = we_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q    <= BASE;
      count_q <= '0;
    end else begin
      sp_q    <= sp_nxt;
      count_q <= CNT_W'(BASE - sp_nxt);
    end
  end

`ifdef SP_BOUNDS_CHECK_EN
  logic in_range;
  logic ovf_set;
  logic unf_set;
  logic bad_set;
  logic overflow_q;
  logic underflow_q;
  logic bad_load_q;

  assign in_range = (load_value >= LIMIT) && (load_value <= BASE);
  assign push_blk = full;
  assign pop_blk  = empty;
  assign load_ok  = in_range;

  assign bad_set = load & ~in_range;
  assign ovf_set = ~load & push & ~pop & full;
  assign unf_set = ~load & pop & empty;

  // Set beats clear so an error coinciding with err_clr is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      bad_load_q  <= 1'b0;
    end else begin
      if (ovf_set)      overflow_q <= 1'b1;
      else if (err_clr) overflow_q <= 1'b0;
      if (unf_set)      underflow_q <= 1'b1;
      else if (err_clr) underflow_q <= 1'b0;
      if (bad_set)      bad_load_q <= 1'b1;
      else if (err_clr) bad_load_q <= 1'b0;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign bad_load  = bad_load_q;
`else
  logic unused_err_clr;

  assign push_blk       = 1'b0;
  assign pop_blk        = 1'b0;
  assign load_ok        = 1'b1;
  assign unused_err_clr = err_clr ^ LIMIT[0];
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
  assign bad_load       = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ctrl.sv
// Directed bench for sp_ctrl; expectations follow SP_BOUNDS_CHECK_EN as compiled.
module tb_sp_ctrl;

`ifdef SP_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, load, err_clr;
  logic [31:0] load_value;
  logic [31:0] sp, mem_addr;
  logic        mem_we;
  logic [15:0] count;
  logic        empty, full, overflow, underflow, bad_load;

  int n_tests = 0;
  int n_fail  = 0;

  sp_ctrl #(.ADDR_W(32), .STACK_BASE(900), .STACK_DEPTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .load(load),
    .load_value(load_value), .err_clr(err_clr), .sp(sp), .mem_addr(mem_addr),
    .mem_we(mem_we), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .bad_load(bad_load)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply a command at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic pu, input logic po, input logic ld,
                       input logic [31:0] lv, input logic ec);
    @(negedge clk);
    push = pu; pop = po; load = ld; load_value = lv; err_clr = ec;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; load = 1'b0; err_clr = 1'b0; load_value = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b1; pop = 1'b0; load = 1'b0; err_clr = 1'b0; load_value = '0;
    #3;
    check("rst_sp", sp, 900);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 900);
    check("rst_flags", {overflow, underflow, bad_load}, 0);
    @(negedge clk);
    @(negedge clk);
    push = 1'b0;
    rst  = 1'b0;

    // Three pushes
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      check("push_addr", mem_addr, 900 - i);
      check("push_we", mem_we, 1);
    end
    idle();
    check("push3_sp", sp, 897);
    check("push3_count", count, 3);

    // Two pops then replace
    drive(0, 1, 0, 0, 0);
    check("pop1_addr", mem_addr, 898);
    check("pop1_we", mem_we, 0);
    drive(0, 1, 0, 0, 0);
    check("pop2_addr", mem_addr, 899);
    check("pop2_we", mem_we, 0);
    drive(1, 1, 0, 0, 0);
    check("pop2_sp", sp, 899);
    check("pop2_count", count, 1);
    check("repl_addr", mem_addr, 900);
    check("repl_we", mem_we, 1);
    idle();
    check("repl_sp", sp, 899);

    // Fill to full, then push beyond
    do_reset();
    for (int i = 0; i < 64; i++) drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("full_sp", sp, 836);
    check("full_flag", full, 1);
    check("full_count", count, 64);
    check("ovf_we", mem_we, CHK ? 0 : 1);
    idle();
    check("ovf_sp", sp, CHK ? 836 : 835);
    check("ovf_flag", overflow, CHK ? 1 : 0);
    check("ovf_full", full, CHK ? 1 : 0);
    drive(1, 0, 0, 0, 1);
    idle();
    check("ovf_setwins", overflow, CHK ? 1 : 0);
    check("ovf_hold_sp", sp, CHK ? 836 : 834);
    drive(0, 0, 0, 0, 1);
    idle();
    check("ovf_clr", overflow, 0);

    // Pop from empty, loads in and out of range
    do_reset();
    drive(0, 1, 0, 0, 0);
    check("unf_we", mem_we, 0);
    idle();
    check("unf_sp", sp, CHK ? 900 : 901);
    check("unf_count", count, CHK ? 0 : 65535);
    check("unf_flag", underflow, CHK ? 1 : 0);
    drive(1, 0, 1, 850, 0);
    check("load_we", mem_we, 0);
    check("load_addr", mem_addr, CHK ? 900 : 901);
    idle();
    check("load_sp", sp, 850);
    check("load_count", count, 50);
    drive(0, 0, 1, 1000, 0);
    idle();
    check("badld_sp", sp, CHK ? 850 : 1000);
    check("badld_count", count, CHK ? 50 : 65436);
    check("badld_flag", bad_load, CHK ? 1 : 0);
    check("unf_sticky", underflow, CHK ? 1 : 0);

    // Replace on empty and load range edges
    do_reset();
    drive(1, 1, 0, 0, 0);
    check("repl_empty_we", mem_we, CHK ? 0 : 1);
    idle();
    check("repl_empty_sp", sp, 900);
    check("repl_empty_unf", underflow, CHK ? 1 : 0);
    drive(0, 0, 1, 836, 0);
    idle();
    check("ld_low_sp", sp, 836);
    check("ld_low_full", full, 1);
    check("ld_low_bad", bad_load, 0);
    drive(0, 0, 1, 835, 0);
    idle();
    check("ld_under_sp", sp, CHK ? 836 : 835);
    check("ld_under_bad", bad_load, CHK ? 1 : 0);
    drive(0, 0, 1, 900, 1);
    idle();
    check("ld_top_sp", sp, 900);
    check("ld_top_empty", empty, 1);
    check("errclr_all", {overflow, underflow, bad_load}, 0);

    // Asynchronous reset in the middle of a push
    do_reset();
    drive(0, 0, 1, 880, 0);
    drive(1, 0, 0, 0, 0);
    check("arst_pre_sp", sp, 880);
    check("arst_pre_we", mem_we, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_sp", sp, 900);
    check("arst_we", mem_we, 0);
    check("arst_count", count, 0);
    @(negedge clk);
    rst = 1'b0; push = 1'b0;
    #1;
    check("arst_after_sp", sp, 900);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
